// File: rtl/round_robin_arbiter_if.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter_if
//
// Bundles the request/grant handshake of the round-robin arbiter.
//
// Signals:
//   requests     WIDTH        request vector, bit i set = requester i wants access
//   grant        WIDTH        one-hot grant, all-zero when grant_valid = 0
//   grant_index  INDEX_WIDTH  binary index of the granted requester, 0 when idle
//   grant_valid  1            a grant is being presented
//   grant_ready  1            consumer accepts the presented grant
//
// Handshake: a grant transfers on a rising clock edge where
// grant_valid & grant_ready. While grant_valid is high, grant and grant_index
// stay stable until that transfer. grant_ready has no meaning while
// grant_valid is low.
//
// Modports:
//   master  arbiter side (drives the grant, reads requests and grant_ready)
//   slave   requester/consumer side
// -----------------------------------------------------------------------------
interface round_robin_arbiter_if #(
    parameter int WIDTH = 8
);
    localparam int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]       requests;
    logic [WIDTH-1:0]       grant;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   grant_valid;
    logic                   grant_ready;

    modport master (
        input  requests,
        input  grant_ready,
        output grant,
        output grant_index,
        output grant_valid
    );

    modport slave (
        output requests,
        output grant_ready,
        input  grant,
        input  grant_index,
        input  grant_valid
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
//
// Registered round-robin arbiter. Picks one requester from a WIDTH-bit request
// vector, scanning from a rotating priority pointer, and presents it as a held
// one-hot grant with a valid/ready handshake. Once presented, a grant is a
// lock: request changes are ignored until the handshake.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   arb            round_robin_arbiter_if.master (requests, grant, grant_index,
//                  grant_valid, grant_ready); must be built with the same WIDTH
//   debug_state    current FSM state (S_IDLE / S_GRANT)
//   debug_pointer  current priority pointer
//
// Handshake: a grant transfers on a rising edge with grant_valid & grant_ready.
// grant/grant_index are stable from the edge that raises grant_valid up to and
// including the transfer edge; grant_ready is ignored while grant_valid is low.
//
// All outputs come straight from flops; there is no combinational path from
// requests or grant_ready to any output.
// -----------------------------------------------------------------------------
module round_robin_arbiter #(
    parameter  int WIDTH       = 8,
    localparam int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    round_robin_arbiter_if.master  arb,
    output logic [0:0]             debug_state,
    output logic [INDEX_WIDTH-1:0] debug_pointer
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(WIDTH - 1);

    logic [0:0]             state_q;
    logic [WIDTH-1:0]       grant_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [INDEX_WIDTH-1:0] pointer_q;

    logic                   handshake;
    logic [INDEX_WIDTH-1:0] pointer_after_hs;
    logic [INDEX_WIDTH-1:0] search_pointer;
    logic [WIDTH-1:0]       upper_mask;
    logic [WIDTH-1:0]       masked_requests;
    logic [WIDTH-1:0]       search_vector;
    logic                   any_request;
    logic [INDEX_WIDTH-1:0] select_index;
    logic [WIDTH-1:0]       select_onehot;

    // Lowest set bit of v; 0 when v is empty (callers gate on any_request).
    function automatic logic [INDEX_WIDTH-1:0] first_one(input logic [WIDTH-1:0] v);
        logic [INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = INDEX_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    assign handshake = (state_q == S_GRANT) && arb.grant_ready;

    // Pointer value written on a handshake: one past the granted index, with
    // the top requester wrapping back to 0.
    assign pointer_after_hs = (index_q == LAST_INDEX) ? '0 : index_q + INDEX_WIDTH'(1);

    // On a handshake the re-arbitration must already see the new pointer,
    // otherwise the requester just served could win again immediately.
    assign search_pointer = handshake ? pointer_after_hs : pointer_q;

    // Rotating priority as two fixed-priority searches: first among bits at or
    // above the pointer, and if none of those request, over the whole vector
    // (which then finds the wrapped-around winner below the pointer).
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upper_mask[i] = (i >= int'(search_pointer));
        end
    end

    assign masked_requests = arb.requests & upper_mask;
    assign search_vector   = (|masked_requests) ? masked_requests : arb.requests;
    assign any_request     = |arb.requests;
    assign select_index    = first_one(search_vector);

    always_comb begin
        select_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            select_onehot[i] = (int'(select_index) == i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Drops any outstanding grant without advancing the pointer.
            state_q   <= S_IDLE;
            grant_q   <= '0;
            index_q   <= '0;
            pointer_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_request) begin
                        state_q <= S_GRANT;
                        grant_q <= select_onehot;
                        index_q <= select_index;
                    end
                end
                S_GRANT: begin
                    // Without grant_ready the grant is held regardless of requests.
                    if (arb.grant_ready) begin
                        pointer_q <= pointer_after_hs;
                        if (any_request) begin
                            grant_q <= select_onehot;
                            index_q <= select_index;
                        end else begin
                            state_q <= S_IDLE;
                            grant_q <= '0;
                            index_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    index_q <= '0;
                end
            endcase
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_index = index_q;
    assign arb.grant_valid = (state_q == S_GRANT);

    assign debug_state   = state_q;
    assign debug_pointer = pointer_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// tb_round_robin_arbiter
//
// Four arbiter instances (WIDTH 4, 8, 1, 5). Directed phases push expected
// outputs written out by hand; the WIDTH=5 soak pushes outputs predicted by a
// rotating-scan reference model. Monitors pop and compare on every falling edge.
// -----------------------------------------------------------------------------
module tb_round_robin_arbiter;

    logic clock;
    logic rst4, rst8, rst1, rst5;

    round_robin_arbiter_if #(.WIDTH(4)) if4 ();
    round_robin_arbiter_if #(.WIDTH(8)) if8 ();
    round_robin_arbiter_if #(.WIDTH(1)) if1 ();
    round_robin_arbiter_if #(.WIDTH(5)) if5 ();

    logic [0:0] dbg_s4, dbg_s8, dbg_s1, dbg_s5;
    logic [1:0] dbg_p4;
    logic [2:0] dbg_p8;
    logic [0:0] dbg_p1;
    logic [2:0] dbg_p5;

    round_robin_arbiter #(.WIDTH(4)) dut4 (.clock(clock), .reset(rst4), .arb(if4),
                                          .debug_state(dbg_s4), .debug_pointer(dbg_p4));
    round_robin_arbiter #(.WIDTH(8)) dut8 (.clock(clock), .reset(rst8), .arb(if8),
                                          .debug_state(dbg_s8), .debug_pointer(dbg_p8));
    round_robin_arbiter #(.WIDTH(1)) dut1 (.clock(clock), .reset(rst1), .arb(if1),
                                          .debug_state(dbg_s1), .debug_pointer(dbg_p1));
    round_robin_arbiter #(.WIDTH(5)) dut5 (.clock(clock), .reset(rst5), .arb(if5),
                                          .debug_state(dbg_s5), .debug_pointer(dbg_p5));

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- scoreboard state ----------------
    // entry = {valid, index[2:0], grant[7:0]}
    logic [11:0] exp_q4[$];
    logic [11:0] exp_q8[$];
    logic [11:0] exp_q1[$];
    logic [11:0] exp_q5[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [11:0] pack(input logic v, input int idx, input logic [7:0] g);
        return {v, 3'(idx), g};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got valid=%0b index=%0d grant=%b, expected valid=%0b index=%0d grant=%b",
                     name, act[11], act[10:8], act[7:0], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    // ---------------- reference model (WIDTH=5 soak) ----------------
    // First requester found walking p, p+1, ... around the ring; -1 if none.
    function automatic int rr_pick(input logic [7:0] req, input int p, input int w);
        int i;
        for (int k = 0; k < w; k++) begin
            i = (p + k) % w;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    int m_valid, m_idx, m_ptr;
    logic [4:0] req5;

    // ---------------- driver ----------------
    task automatic drive(input int d, input logic [7:0] req, input logic rdy, input logic rst,
                         input logic ev, input int ei, input logic [7:0] eg);
        case (d)
            4: begin if4.requests = req[3:0]; if4.grant_ready = rdy; rst4 = rst; end
            8: begin if8.requests = req;      if8.grant_ready = rdy; rst8 = rst; end
            1: begin if1.requests = req[0:0]; if1.grant_ready = rdy; rst1 = rst; end
            default: begin if5.requests = req[4:0]; if5.grant_ready = rdy; rst5 = rst; end
        endcase
        @(posedge clock);
        case (d)
            4: exp_q4.push_back(pack(ev, ei, eg));
            8: exp_q8.push_back(pack(ev, ei, eg));
            1: exp_q1.push_back(pack(ev, ei, eg));
            default: exp_q5.push_back(pack(ev, ei, eg));
        endcase
        #1;
    endtask

    task automatic soak(input int cycles);
        logic rdy;
        int a;
        for (int c = 0; c < cycles; c++) begin
            // A request stays up until granted; only the granted requester may drop.
            for (int i = 0; i < 5; i++) begin
                if (req5[i]) begin
                    if (m_valid != 0 && m_idx == i && $urandom_range(0, 3) == 0) req5[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req5[i] = 1'b1;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            if5.requests    = req5;
            if5.grant_ready = rdy;
            rst5            = 1'b0;
            @(posedge clock);
            if (m_valid == 0) begin
                a = rr_pick({3'b000, req5}, m_ptr, 5);
                if (a >= 0) begin
                    m_valid = 1;
                    m_idx   = a;
                end
            end else if (rdy) begin
                m_ptr = (m_idx + 1) % 5;
                a = rr_pick({3'b000, req5}, m_ptr, 5);
                if (a >= 0) begin
                    m_idx = a;
                end else begin
                    m_valid = 0;
                    m_idx   = 0;
                end
            end
            exp_q5.push_back(pack(m_valid != 0, m_idx, (m_valid != 0) ? 8'(1 << m_idx) : 8'h00));
            #1;
        end
    endtask

    // ---------------- monitors ----------------
    logic [11:0] e4, e8, e1, e5;

    always @(negedge clock) begin
        if (exp_q4.size() > 0) begin
            e4 = exp_q4.pop_front();
            check("w4_out", {if4.grant_valid, 3'(if4.grant_index), 8'(if4.grant)}, e4);
        end
        if (exp_q8.size() > 0) begin
            e8 = exp_q8.pop_front();
            check("w8_out", {if8.grant_valid, 3'(if8.grant_index), 8'(if8.grant)}, e8);
        end
        if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            check("w1_out", {if1.grant_valid, 3'(if1.grant_index), 8'(if1.grant)}, e1);
        end
        if (exp_q5.size() > 0) begin
            e5 = exp_q5.pop_front();
            check("w5_out", {if5.grant_valid, 3'(if5.grant_index), 8'(if5.grant)}, e5);
        end
    end

    // Soak-only properties: grant held while not accepted, and bounded waiting.
    logic       soak_on = 1'b0;
    int         wait5[5];
    logic       prev_hold;
    logic [4:0] prev_grant;
    int         g;

    always @(negedge clock) begin
        if (soak_on) begin
            if (prev_hold) begin
                check("w5_hold", {if5.grant_valid, 6'd0, if5.grant}, {1'b1, 6'd0, prev_grant});
            end
            prev_hold  = if5.grant_valid && !if5.grant_ready;
            prev_grant = if5.grant;
            if (if5.grant_valid && if5.grant_ready) begin
                g = int'(if5.grant_index);
                for (int i = 0; i < 5; i++) begin
                    if (i == g) begin
                        n_checks++;
                        if (wait5[i] > 4) begin
                            n_errors++;
                            $display("FAIL w5_starve: requester %0d waited %0d handshakes, limit 4", i, wait5[i]);
                        end
                        wait5[i] = 0;
                    end else if (if5.requests[i]) begin
                        wait5[i]++;
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst4 = 1'b1; rst8 = 1'b1; rst1 = 1'b1; rst5 = 1'b1;
        if4.requests = '0; if4.grant_ready = 1'b0;
        if8.requests = '0; if8.grant_ready = 1'b0;
        if1.requests = '0; if1.grant_ready = 1'b0;
        if5.requests = '0; if5.grant_ready = 1'b0;

        // WIDTH=4: reset, basic grant and wrap
        drive(4, 8'h0, 0, 1, 0, 0, 8'h00);
        drive(4, 8'hA, 0, 0, 1, 1, 8'h02);
        drive(4, 8'hA, 1, 0, 1, 3, 8'h08);
        drive(4, 8'hA, 1, 0, 1, 1, 8'h02);
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);   // pointer now 2

        // WIDTH=4: full rotation from a fresh reset
        drive(4, 8'h0, 0, 1, 0, 0, 8'h00);
        drive(4, 8'hF, 1, 0, 1, 0, 8'h01);
        drive(4, 8'hF, 1, 0, 1, 1, 8'h02);
        drive(4, 8'hF, 1, 0, 1, 2, 8'h04);
        drive(4, 8'hF, 1, 0, 1, 3, 8'h08);
        drive(4, 8'hF, 1, 0, 1, 0, 8'h01);
        drive(4, 8'hF, 1, 0, 1, 1, 8'h02);
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);   // pointer now 2

        // WIDTH=4: lock while not ready, then pointer wraps to 0
        drive(4, 8'h8, 0, 0, 1, 3, 8'h08);
        for (int i = 0; i < 5; i++) drive(4, 8'h4, 0, 0, 1, 3, 8'h08);
        drive(4, 8'h4, 1, 0, 1, 2, 8'h04);
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);   // pointer now 3

        // WIDTH=4: drain to idle, ready ignored while idle
        drive(4, 8'h1, 0, 0, 1, 0, 8'h01);
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);   // pointer now 1
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);
        drive(4, 8'h1, 0, 0, 1, 0, 8'h01);
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);   // pointer still 1
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);
        drive(4, 8'hF, 0, 0, 1, 1, 8'h02);
        drive(4, 8'h0, 1, 0, 0, 0, 8'h00);

        // WIDTH=8: reset overrides handshake, pointer not advanced
        drive(8, 8'h00, 0, 1, 0, 0, 8'h00);
        drive(8, 8'h20, 0, 0, 1, 5, 8'h20);
        drive(8, 8'h20, 1, 1, 0, 0, 8'h00);
        drive(8, 8'hFF, 0, 0, 1, 0, 8'h01);
        drive(8, 8'hFF, 1, 0, 1, 1, 8'h02);
        drive(8, 8'h00, 1, 0, 0, 0, 8'h00);

        // WIDTH=1: continuous grant, lock, drain
        drive(1, 8'h0, 0, 1, 0, 0, 8'h00);
        drive(1, 8'h1, 1, 0, 1, 0, 8'h01);
        drive(1, 8'h1, 1, 0, 1, 0, 8'h01);
        drive(1, 8'h1, 1, 0, 1, 0, 8'h01);
        drive(1, 8'h0, 0, 0, 1, 0, 8'h01);
        drive(1, 8'h0, 1, 0, 0, 0, 8'h00);
        drive(1, 8'h0, 1, 0, 0, 0, 8'h00);

        // WIDTH=5: random soak against the reference model
        drive(5, 8'h0, 0, 1, 0, 0, 8'h00);
        m_valid = 0; m_idx = 0; m_ptr = 0; req5 = '0;
        for (int i = 0; i < 5; i++) wait5[i] = 0;
        prev_hold = 1'b0;
        prev_grant = '0;
        soak_on = 1'b1;
        soak(10000);
        soak_on = 1'b0;

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q4.size() + exp_q8.size() + exp_q1.size() + exp_q5.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0",
                     exp_q4.size() + exp_q8.size() + exp_q1.size() + exp_q5.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
